// File: rtl/vedic_mul8_seq.sv
// vedic_mul8_seq: 8x8 unsigned multiply/accumulate sequenced over a shared 4x4 core in four steps
module vedic_mul8_seq #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_p,
  output logic             out_ovf,
  output logic             busy,
  output logic [3:0]       core_a,
  output logic [3:0]       core_b,
  input  logic [7:0]       core_p
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;
  logic [7:0] a, b;
  logic [1:0] step;
  logic [ACC_W-1:0] acc, addend;
  logic ovf;
  logic [ACC_W:0] sum;
  logic [3:0] sh;
  assign in_ready = rst_n && state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign sh = step == 2'd3 ? 4'd8 : step == 2'd0 ? 4'd0 : 4'd4;
  assign addend = ACC_W'(core_p) << sh;
  assign sum = {1'b0, acc} + {1'b0, addend};
  // next state and nibble steering into the shared core
  always_comb begin
    state_n = state;
    core_a = '0;
    core_b = '0;
    case (state)
      IDLE: if (in_valid) state_n = MUL;
      MUL: begin
        core_a = step[0] ? a[7:4] : a[3:0];
        core_b = step[1] ? b[7:4] : b[3:0];
        if (step == 2'd3) state_n = DONE;
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, operand latch, shift-accumulate and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      step <= '0;
      acc <= '0;
      ovf <= 1'b0;
      out_p <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        a <= in_a;
        b <= in_b;
        acc <= in_acc ? acc : '0;
        ovf <= 1'b0;
        step <= '0;
      end
      if (state == MUL) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
        step <= step + 2'd1;
        if (step == 2'd3) begin
          out_p <= sum[ACC_W-1:0];
          out_ovf <= ovf | sum[ACC_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul8_seq.sv
// tb_vedic_mul8_seq: scoreboard bench for the sequenced 8x8 multiplier (ACC_W=20 and ACC_W=16 instances)
module tb_vedic_mul8_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [19:0] out_p;
  logic [3:0] core_a, core_b;
  logic [7:0] core_p;
  logic in_ready16, out_valid16, out_ovf16, busy16;
  logic [15:0] out_p16;
  logic [3:0] core_a16, core_b16;
  logic [7:0] core_p16;
  typedef struct packed {logic [19:0] p; logic ovf; logic [15:0] p16; logic ovf16;} exp_t;
  exp_t sb[$];
  logic [19:0] mdl = '0;
  logic [15:0] mdl16 = '0;
  logic [3:0] ca [4], cb [4];
  int checks = 0, errors = 0;

  assign core_p = {4'd0, core_a} * {4'd0, core_b};
  assign core_p16 = {4'd0, core_a16} * {4'd0, core_b16};
  always #5 clk = ~clk;

  vedic_mul8_seq #(.ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf),
    .busy(busy), .core_a(core_a), .core_b(core_b), .core_p(core_p)
  );
  vedic_mul8_seq #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .in_acc(in_acc), .out_valid(out_valid16), .out_ready(out_ready), .out_p(out_p16), .out_ovf(out_ovf16),
    .busy(busy16), .core_a(core_a16), .core_b(core_b16), .core_p(core_p16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] pr;
    logic [20:0] f;
    logic [16:0] f16;
    exp_t e;
    pr = {8'd0, a} * {8'd0, b};
    f = (m ? {1'b0, mdl} : 21'd0) + {5'd0, pr};
    f16 = (m ? {1'b0, mdl16} : 17'd0) + {1'b0, pr};
    e.p = f[19:0];
    e.ovf = f[20];
    e.p16 = f16[15:0];
    e.ovf16 = f16[16];
    mdl = f[19:0];
    mdl16 = f16[15:0];
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m, output exp_t got, output int lat);
    in_a = a; in_b = b; in_acc = m; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    got = '0;
    push_exp(a, b, m);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (c <= 4) begin ca[c-1] = core_a; cb[c-1] = core_b; end
      if (out_valid) begin
        lat = c;
        got.p = out_p; got.ovf = out_ovf; got.p16 = out_p16; got.ovf16 = out_ovf16;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({out_p, out_ovf, out_valid, busy, in_ready, core_a, core_b} !== 33'd0) begin errors++; $display("FAIL reset_outputs got p=%h ovf=%b v=%b busy=%b rdy=%b ca=%h cb=%h expected all 0", out_p, out_ovf, out_valid, busy, in_ready, core_a, core_b); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({busy, in_ready, core_a, core_b, out_valid} !== 11'b0_1_0000_0000_0) begin errors++; $display("FAIL idle_c%0d got busy=%b rdy=%b ca=%h cb=%h v=%b expected 0 1 0 0 0", i, busy, in_ready, core_a, core_b, out_valid); end
    end
  endtask

  task automatic test_basic();
    exp_t g, e;
    int lat;
    logic [7:0] pairs [4] = '{8'h24, 8'h14, 8'h23, 8'h13};
    run_op(8'h12, 8'h34, 1'b0, g, lat);
    e = sb.pop_front();
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d expected 5", lat); end
    checks++; if (g.p !== e.p) begin errors++; $display("FAIL basic_p got %h expected %h", g.p, e.p); end
    checks++; if (g.p !== 20'h003A8) begin errors++; $display("FAIL basic_p_const got %h expected 003a8", g.p); end
    checks++; if (g.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b expected 0", g.ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({ca[i], cb[i]} !== pairs[i]) begin errors++; $display("FAIL basic_core_step%0d got %h%h expected %h", i, ca[i], cb[i], pairs[i]); end
    end
  endtask

  task automatic test_acc();
    exp_t g, e;
    int lat;
    run_op(8'hFF, 8'hFF, 1'b0, g, lat);
    e = sb.pop_front();
    checks++; if (g.p !== e.p) begin errors++; $display("FAIL mul_ff_p got %h expected %h", g.p, e.p); end
    checks++; if (g.p16 !== e.p16 || g.ovf16 !== e.ovf16) begin errors++; $display("FAIL mul_ff_p16 got %h/%b expected %h/%b", g.p16, g.ovf16, e.p16, e.ovf16); end
    run_op(8'hFF, 8'hFF, 1'b1, g, lat);
    e = sb.pop_front();
    checks++; if (g.p !== e.p) begin errors++; $display("FAIL mac_p got %h expected %h", g.p, e.p); end
    checks++; if (g.ovf !== e.ovf) begin errors++; $display("FAIL mac_ovf got %b expected %b", g.ovf, e.ovf); end
    checks++; if (g.p16 !== e.p16) begin errors++; $display("FAIL mac16_p got %h expected %h", g.p16, e.p16); end
    checks++; if (g.ovf16 !== e.ovf16) begin errors++; $display("FAIL mac16_ovf got %b expected %b", g.ovf16, e.ovf16); end
  endtask

  task automatic test_hold();
    exp_t g, e;
    int lat;
    logic [19:0] hp;
    in_a = 8'h11; in_b = 8'h22; in_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    push_exp(8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 30 && !out_valid; c++) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got out_valid=%b expected 1", out_valid); end
    hp = out_p;
    e = sb.pop_front();
    checks++; if (hp !== e.p) begin errors++; $display("FAIL hold_p got %h expected %h", hp, e.p); end
    for (int k = 0; k < 3; k++) begin
      in_a = 8'h55; in_b = 8'h66; in_valid = 1'b1;
      tick();
      checks++; if ({out_valid, in_ready, busy} !== 3'b101 || out_p !== hp) begin errors++; $display("FAIL hold_c%0d got v=%b rdy=%b busy=%b p=%h expected 1 0 1 %h", k, out_valid, in_ready, busy, out_p, hp); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01 || out_p !== hp) begin errors++; $display("FAIL hold_release got v=%b rdy=%b p=%h expected 0 1 %h", out_valid, in_ready, out_p, hp); end
    run_op(8'h55, 8'h66, 1'b0, g, lat);
    e = sb.pop_front();
    checks++; if (g.p !== e.p || lat !== 5) begin errors++; $display("FAIL hold_next got %h lat %0d expected %h lat 5", g.p, lat, e.p); end
  endtask

  task automatic test_reset_mid();
    exp_t g, e;
    int lat;
    in_a = 8'hAB; in_b = 8'hCD; in_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if ({core_a, core_b} !== 8'hBC) begin errors++; $display("FAIL rmid_step2_core got %h%h expected bc", core_a, core_b); end
    rst_n = 1'b0;
    #1;
    checks++; if ({out_p, out_ovf, out_valid, busy, in_ready, core_a, core_b} !== 33'd0) begin errors++; $display("FAIL rmid_outputs got p=%h ovf=%b v=%b busy=%b rdy=%b ca=%h cb=%h expected all 0", out_p, out_ovf, out_valid, busy, in_ready, core_a, core_b); end
    mdl = '0;
    mdl16 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got rdy=%b busy=%b expected 1 0", in_ready, busy); end
    run_op(8'hAB, 8'hCD, 1'b1, g, lat);
    e = sb.pop_front();
    checks++; if (g.p !== e.p || g.ovf !== e.ovf) begin errors++; $display("FAIL rmid_p got %h/%b expected %h/%b", g.p, g.ovf, e.p, e.ovf); end
    checks++; if (g.p !== 20'h088EF) begin errors++; $display("FAIL rmid_p_const got %h expected 088ef", g.p); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [3] = '{8'h00, 8'h80, 8'h0F};
    logic [7:0] pb [3] = '{8'h7F, 8'h02, 8'hF0};
    int rc [3] = '{5, 11, 17};
    int idx = 0, nres = 0;
    logic acc_now;
    exp_t e;
    in_a = pa[0]; in_b = pb[0]; in_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      acc_now = in_valid && in_ready;
      if (acc_now) push_exp(in_a, in_b, 1'b0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_unexpected got result %h at cycle %0d expected none", out_p, t);
        end else begin
          e = sb.pop_front();
          checks++; if (out_p !== e.p) begin errors++; $display("FAIL b2b_p%0d got %h expected %h", nres, out_p, e.p); end
          if (nres < 3) begin
            checks++; if (t !== rc[nres]) begin errors++; $display("FAIL b2b_cycle%0d got %0d expected %0d", nres, t, rc[nres]); end
          end
        end
        nres++;
      end
      tick();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_count got %0d expected 3", nres); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_acc();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vedic_mul8_seq.md
Name: vedic_mul8_seq

Overview:
Sequencer that computes 8x8 unsigned products by time-multiplexing one external combinational vedic_4x4 core over four cycles. It splits the operands into nibbles, drives the core's a/b inputs, and shift-accumulates the core's 8-bit result into a wide accumulator. It has valid/ready handshakes on input and output, and an optional multiply-accumulate mode. It sits between the I/O wrapper and the shared 4x4 core.

Parameters:
ACC_W, 20, accumulator/result width in bits; legal range 16..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
in_a  input  8  multiplicand, unsigned
in_b  input  8  multiplier, unsigned
in_acc  input  1  1 = add product to previous result; 0 = start from zero
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_p  output  ACC_W  result (product or accumulated sum)
out_ovf  output  1  this operation's accumulation wrapped past ACC_W bits
busy  output  1  state != IDLE
core_a  output  4  to shared 4x4 core a input
core_b  output  4  to shared 4x4 core b input
core_p  input  8  from shared 4x4 core, combinational (core_a*core_b) in the same cycle

Behaviour:
- Reset is asynchronous, active-low; clk and rst_n are the single clock and reset. On reset, immediately and at any time including mid-operation:
  - state=IDLE, acc=0, out_p=0, out_ovf=0, out_valid=0, core_a=0, core_b=0, busy=0, step counter=0.
  - in_ready=1 once rst_n deasserts.
- States: IDLE, MUL (2-bit step 0..3), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_a, in_b and in_acc. If in_acc=0, acc<=0; otherwise acc keeps the previous result. Clear the ovf flag, step<=0, go to MUL.
- MUL, one step per cycle:
  - step0: core_a=a[3:0], core_b=b[3:0], add core_p<<0.
  - step1: core_a=a[7:4], core_b=b[3:0], add core_p<<4.
  - step2: core_a=a[3:0], core_b=b[7:4], add core_p<<4.
  - step3: core_a=a[7:4], core_b=b[7:4], add core_p<<8.
  - Each addition is modulo 2^ACC_W and is registered at the end of its step cycle.
  - Any carry out of bit ACC_W-1 sets the sticky ovf flag.
  - After step3, go to DONE.
- Outside MUL, core_a=core_b=0.
- DONE:
  - out_valid=1; out_p=acc and out_ovf=ovf, both held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE, out_valid drops on the next edge.
  - out_p and out_ovf keep their value after the handshake until the next operation updates them.
- in_ready=0 in MUL and DONE; in_valid is ignored there, and in_a/in_b changes have no effect.
- Latency: acceptance in cycle 0, steps in cycles 1..4, out_valid=1 from cycle 5.
- Throughput: if out_ready=1 in cycle 5, IDLE is reached in cycle 6, giving one result per 6 cycles.
- Accumulation: with in_acc=1, the first operation after reset accumulates onto 0.
- Arithmetic: all operands are unsigned. The full 16-bit product is always exact when ACC_W>=16 and in_acc=0.

Test Plan:
1. in_a=0x12, in_b=0x34, in_acc=0, out_ready=1 -> core (a,b) in cycles 1..4 = (2,4),(1,4),(2,3),(1,3); out_valid in cycle 5; out_p=0x003A8; out_ovf=0.
2. in_a=0xFF, in_b=0xFF, in_acc=0 -> out_p=0x0FE01. Follow with the same operands and in_acc=1 -> out_p=0x1FC02, out_ovf=0. With an ACC_W=16 instance, the second result -> out_p=0xFC02, out_ovf=1.
3. Hold out_ready=0 for 3 cycles after out_valid, pulsing in_valid with new operands -> out_valid and out_p stay constant, in_ready=0, new operands are not accepted; release out_ready -> IDLE, then the new request is accepted.
4. Assert rst_n=0 during step2 of 0xAB*0xCD -> all outputs 0 immediately. Release reset, then issue 0xAB*0xCD -> out_p=0x088EF.
5. Back-to-back: in_valid=1 and out_ready=1 continuously with operand pairs (0x00,0x7F), (0x80,0x02), (0x0F,0xF0) -> results 0x00000, 0x00100, 0x00E10 in cycles 5, 11, 17.
6. Idle check: no in_valid for 10 cycles after reset -> busy=0, in_ready=1, core_a=core_b=0, out_valid=0.
